// File: rtl/counter_pkg.sv
// counter_pkg: direction/mode constants and parameter legality check for mod_counter
package counter_pkg;
  localparam bit DIR_UP    = 1'b1;
  localparam bit DIR_DOWN  = 1'b0;
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;
  function automatic bit params_ok(int width, longint max_val, int prescale);
    return max_val >= 1 && max_val <= (longint'(1) << width) - 1 && prescale >= 1;
  endfunction
endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle of mod_counter
interface mod_counter_if #(parameter int WIDTH = 4);
  logic             clear;
  logic             enable;
  logic             up;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             overflow;
  logic             at_max;
  logic             at_min;
  modport master (
    output clear, enable, up, sat_mode, load, load_value,
    input  count, wrap, overflow, at_max, at_min
  );
  modport slave (
    input  clear, enable, up, sat_mode, load, load_value,
    output count, wrap, overflow, at_max, at_min
  );
endinterface

// File: rtl/count_prescaler.sv
// count_prescaler: emits step_en on every PRESCALE-th enabled cycle
module count_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic step_en
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_cnt;
  // with PRESCALE = 1 pre_cnt is pinned at 0, so step_en reduces to enable
  assign step_en = enable && pre_cnt == LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pre_cnt <= '0;
    else pre_cnt <= (clear || step_en) ? '0 : enable ? pre_cnt + 1'b1 : pre_cnt;
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with load, clear, wrap/saturate and prescaler
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mod_counter_if.slave  bus
);
  if (!params_ok(WIDTH, MAX_VAL, PRESCALE)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MAX_VAL/PRESCALE");
  end
  localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MAX_VAL);
  logic             step_en;
  logic             at_lim;
  logic             wrap_n;
  logic             ovf_n;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   stepped;
  logic [WIDTH:0]   lv;
  logic [WIDTH-1:0] count_n;
  count_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.clear | bus.load),
    .enable  (bus.enable),
    .step_en (step_en)
  );
  always_comb begin
    ext     = {1'b0, bus.count};
    at_lim  = (bus.up == DIR_UP) ? ext == MAXV : ext == '0;
    stepped = (bus.up == DIR_UP) ? ext + 1'b1 : ext - 1'b1;
    lv      = ({1'b0, bus.load_value} > MAXV) ? MAXV : {1'b0, bus.load_value};
    count_n = WIDTH'(bus.clear ? '0 : bus.load ? lv : !step_en ? ext : !at_lim ? stepped :
                     (bus.sat_mode == MODE_SAT) ? ext : (bus.up == DIR_UP) ? '0 : MAXV);
    wrap_n  = !bus.clear && !bus.load && step_en && at_lim && bus.sat_mode == MODE_WRAP;
    ovf_n   = !bus.clear && (bus.overflow || (!bus.load && step_en && at_lim));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.count    <= '0;
      bus.wrap     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.count    <= count_n;
      bus.wrap     <= wrap_n;
      bus.overflow <= ovf_n;
    end
  assign bus.at_max = bus.count == MAXV[WIDTH-1:0];
  assign bus.at_min = bus.count == '0;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed checks of mod_counter (MAX_VAL=9, PRESCALE 1 and 3)
module tb_mod_counter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  mod_counter_if #(.WIDTH(4)) a ();
  mod_counter_if #(.WIDTH(4)) b ();
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a));
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b));
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.clear = 0; a.enable = 0; a.up = 1; a.sat_mode = 0; a.load = 0; a.load_value = 0;
  endtask

  task automatic clear_a();
    idle_a();
    a.clear = 1;
    edge1();
    a.clear = 0;
    n_cmp++;
    if (a.count !== 4'd0 || a.overflow !== 1'b0 || a.wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: count=%0d ovf=%b wrap=%b, want 0/0/0", a.count, a.overflow, a.wrap);
    end
  endtask

  task automatic test_reset();
    idle_a();
    b.clear = 0; b.enable = 0; b.up = 1; b.sat_mode = 0; b.load = 0; b.load_value = 0;
    #12;
    n_cmp++;
    if ({a.count, a.wrap, a.overflow, a.at_min, a.at_max} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: count=%0d wrap=%b ovf=%b min=%b max=%b, want 0 0 0 1 0",
               a.count, a.wrap, a.overflow, a.at_min, a.at_max);
    end
    n_cmp++;
    if ({b.count, b.wrap, b.overflow, b.at_min} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_b: count=%0d wrap=%b ovf=%b min=%b, want 0 0 0 1",
               b.count, b.wrap, b.overflow, b.at_min);
    end
    reset_n = 1;
  endtask

  task automatic test_wrap_up();
    int exp_c;
    idle_a();
    a.enable = 1;
    for (int i = 0; i < 12; i++) begin
      edge1();
      exp_c = (i + 1) % 10;
      n_cmp++;
      if (a.count !== 4'(exp_c) || a.wrap !== (i == 9) || a.overflow !== (i >= 9)) begin
        n_bad++;
        $display("FAIL wrap_up[%0d]: count=%0d wrap=%b ovf=%b, want %0d %b %b",
                 i, a.count, a.wrap, a.overflow, exp_c, i == 9, i >= 9);
      end
    end
  endtask

  task automatic test_sat_up();
    int exp_c;
    idle_a();
    a.enable = 1; a.sat_mode = 1;
    for (int i = 0; i < 12; i++) begin
      edge1();
      exp_c = (i + 1 > 9) ? 9 : i + 1;
      n_cmp++;
      if (a.count !== 4'(exp_c) || a.wrap !== 1'b0 || a.overflow !== (i >= 9) || a.at_max !== (exp_c == 9)) begin
        n_bad++;
        $display("FAIL sat_up[%0d]: count=%0d wrap=%b ovf=%b max=%b, want %0d 0 %b %b",
                 i, a.count, a.wrap, a.overflow, a.at_max, exp_c, i >= 9, exp_c == 9);
      end
    end
  endtask

  task automatic test_down();
    idle_a();
    a.enable = 1; a.up = 0;
    edge1();
    n_cmp++;
    if (a.count !== 4'd9 || a.wrap !== 1'b1 || a.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL down_wrap1: count=%0d wrap=%b ovf=%b, want 9 1 1", a.count, a.wrap, a.overflow);
    end
    edge1();
    n_cmp++;
    if (a.count !== 4'd8 || a.wrap !== 1'b0 || a.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL down_wrap2: count=%0d wrap=%b ovf=%b, want 8 0 1", a.count, a.wrap, a.overflow);
    end
    clear_a();
    a.enable = 1; a.up = 0; a.sat_mode = 1;
    edge1();
    n_cmp++;
    if (a.count !== 4'd0 || a.wrap !== 1'b0 || a.overflow !== 1'b1 || a.at_min !== 1'b1) begin
      n_bad++;
      $display("FAIL down_sat: count=%0d wrap=%b ovf=%b min=%b, want 0 0 1 1",
               a.count, a.wrap, a.overflow, a.at_min);
    end
  endtask

  task automatic test_load();
    idle_a();
    a.load = 1; a.load_value = 5; a.enable = 1;
    edge1();
    n_cmp++;
    if (a.count !== 4'd5 || a.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL load_keep_ovf: count=%0d ovf=%b, want 5 1", a.count, a.overflow);
    end
    clear_a();
    a.load = 1; a.load_value = 15; a.enable = 1; a.up = 1;
    edge1();
    n_cmp++;
    if (a.count !== 4'd9 || a.wrap !== 1'b0 || a.overflow !== 1'b0 || a.at_max !== 1'b1) begin
      n_bad++;
      $display("FAIL load_clamp: count=%0d wrap=%b ovf=%b max=%b, want 9 0 0 1",
               a.count, a.wrap, a.overflow, a.at_max);
    end
    clear_a();
  endtask

  task automatic test_prescale();
    logic [3:0] exp_c [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    logic       en_v  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      b.enable = en_v[i];
      edge1();
      n_cmp++;
      if (b.count !== exp_c[i]) begin
        n_bad++;
        $display("FAIL prescale[%0d]: count=%0d, want %0d", i, b.count, exp_c[i]);
      end
    end
    b.enable = 0;
  endtask

  task automatic test_async_reset();
    idle_a();
    a.enable = 1; a.up = 0; a.sat_mode = 1;
    edge1();
    a.up = 1; a.sat_mode = 0;
    for (int i = 0; i < 6; i++) edge1();
    n_cmp++;
    if (a.count !== 4'd6 || a.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: count=%0d ovf=%b, want 6 1", a.count, a.overflow);
    end
    #2;
    reset_n = 0;
    #1;
    n_cmp++;
    if (a.count !== 4'd0 || a.wrap !== 1'b0 || a.overflow !== 1'b0 || a.at_min !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: count=%0d wrap=%b ovf=%b min=%b, want 0 0 0 1",
               a.count, a.wrap, a.overflow, a.at_min);
    end
    #1;
    reset_n = 1;
    edge1();
    n_cmp++;
    if (a.count !== 4'd1) begin
      n_bad++;
      $display("FAIL resume: count=%0d, want 1", a.count);
    end
  endtask

  initial begin
    test_reset();
    edge1();
    test_wrap_up();
    clear_a();
    test_sat_up();
    clear_a();
    test_down();
    test_load();
    test_prescale();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter, the general-purpose successor to the fixed 4-bit up counter. It adds direction control, a configurable terminal value, a synchronous load and clear, a wrap-or-saturate mode, an enable prescaler, and wrap/overflow reporting. It sits anywhere a design needs event, timer or sequence counting, and is sized per instance.

## Interface
- WIDTH, 4: counter width in bits.
- MAX_VAL, 2**WIDTH-1: terminal value. Count range is 0..MAX_VAL. Legal range is 1..2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step. Legal range ≥1; 1 means every enabled cycle.

Ports:
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of count, prescaler and overflow.
- enable  in  1  qualifies the prescaler and stepping.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat_mode  in  1  behaviour at a limit: 1 = saturate, 0 = wrap.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load; clamped to MAX_VAL.
- count  out  WIDTH  current count, registered.
- wrap  out  1  one-cycle pulse, registered.
- overflow  out  1  sticky limit-hit flag, registered.
- at_max  out  1  count == MAX_VAL, decoded from register.
- at_min  out  1  count == 0, decoded from register.

## Operation
- Priority per cycle, highest first: reset_n low, then clear, then load, then step.
- reset_n low (asynchronous):
  - count = 0, prescaler = 0, wrap = 0, overflow = 0.
  - Hence at_min = 1 and at_max = 0, except at_max = 1 when MAX_VAL = 0, which is illegal.
- clear: count = 0, prescaler = 0, overflow = 0, wrap = 0.
- load:
  - count = min(load_value, MAX_VAL); prescaler = 0; wrap = 0.
  - overflow is unchanged.
  - load overrides enable in the same cycle.
- Prescaler:
  - Internal counter pre_cnt runs 0..PRESCALE-1 and advances only when enable = 1.
  - A step occurs when enable = 1 and pre_cnt = PRESCALE-1; pre_cnt then returns to 0.
  - pre_cnt holds while enable = 0.
- Step, up = 1:
  - count < MAX_VAL: count + 1.
  - count = MAX_VAL, wrap mode: count = 0, wrap pulse, overflow = 1.
  - count = MAX_VAL, sat mode: count holds, no wrap pulse, overflow = 1.
- Step, up = 0:
  - count > 0: count - 1.
  - count = 0, wrap mode: count = MAX_VAL, wrap pulse, overflow = 1.
  - count = 0, sat mode: count holds, no wrap pulse, overflow = 1.
- wrap is 0 in every cycle that has no wrapping step.
- Arithmetic is done in WIDTH+1 bits internally. count never holds a value above MAX_VAL.
- up and sat_mode may change on any cycle and take effect on the next step.

## Timing
- All outputs update on the rising clk edge following the sampled inputs: one-cycle latency.
- wrap is high in the same cycle that count first shows the wrapped value.
- overflow rises in the same cycle as the limit step and stays high until clear or reset.
- at_max and at_min are combinational decodes of the count register and have no extra latency.
- With PRESCALE = N and enable held high, count changes on every Nth edge. The first change comes N edges after enable rises from a cleared prescaler.
- When reset_n deasserts, the first edge with reset_n high may already load or step.

## Structure
- Shared package counter_pkg holds:
  - Direction constants DIR_UP = 1, DIR_DOWN = 0.
  - Mode constants MODE_WRAP = 0, MODE_SAT = 1.
  - The parameter-legality check macro/function, which errors when MAX_VAL = 0, MAX_VAL > 2**WIDTH-1 or PRESCALE < 1.
- Sub-module count_prescaler (parameter PRESCALE):
  - Inputs: clk, reset_n, clear, enable.
  - Output: step_en.
  - When PRESCALE = 1 it collapses to step_en = enable.

## Test plan
- WIDTH=4, MAX_VAL=9, PRESCALE=1, wrap mode, up=1, enable held for 12 cycles from reset → count runs 0..9 then 0,1,2; wrap is high for exactly one cycle when count = 0 after 9; overflow = 1 from then on.
- Same configuration, sat mode, up=1, enable for 12 cycles → count stops at 9; wrap never asserts; overflow rises on the 10th step; at_max = 1 from count = 9.
- up=0 from count 0: wrap mode → 9 then 8 with a wrap pulse; sat mode → holds 0 with overflow = 1.
- load with load_value=15 and MAX_VAL=9, with enable=1 in the same cycle → count = 9 next cycle and no step; clear one cycle later → count = 0, overflow = 0.
- PRESCALE=3, enable high → count increments every 3rd edge; enable dropped mid-period for 2 cycles → pre_cnt holds, so the next step comes 1 enabled cycle after resume if pre_cnt was 1.
- reset_n pulsed low asynchronously mid-count at count = 6, between clock edges → count, wrap and overflow read 0 immediately, before any edge; counting resumes from 0 after deassertion.
